// File: rtl/alu_core.sv
// Registered ALU: eight operations selected by ALU_Sel, result and flags
// captured one cycle after an accepted in_valid, held while idle.
module alu_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             out_valid,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  // Handshake: no backpressure. Every edge with in_valid=1 accepts one
  // operation; out_valid is high for exactly the cycle after an accepted op.

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff_w;
  logic [WIDTH-1:0] res_d, res_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
  logic             zero_q, neg_q, valid_q;

  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign diff_w = A - B;

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        res_d   = sum_w[WIDTH-1:0];
        carry_d = sum_w[WIDTH];
        ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        // carry doubles as the no-borrow indicator
        res_d   = diff_w;
        carry_d = (A >= B);
        ovf_d   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: res_d = A & B;
      OP_OR:  res_d = A | B;
      OP_NOT: res_d = ~A;
      OP_XOR: res_d = A ^ B;
      OP_SHL: begin
        res_d   = {A[WIDTH-2:0], 1'b0};
        carry_d = A[WIDTH-1];
      end
      OP_SHR: begin
        res_d   = {1'b0, A[WIDTH-1:1]};
        carry_d = A[0];
      end
      default: res_d = '0;
    endcase
  end

  // zero/negative are registered alongside the result so reset clears them too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q   <= res_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        zero_q  <= (res_d == '0);
        neg_q   <= res_d[WIDTH-1];
      end
    end
  end

  assign ALU_Out   = res_q;
  assign out_valid = valid_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core (WIDTH=4): hand-computed results and flags.
module tb_alu_core;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] ALU_Sel;
  logic [3:0] ALU_Out;
  logic       out_valid;
  logic       carry;
  logic       zero;
  logic       negative;
  logic       overflow;

  int checks;
  int errors;

  alu_core #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .ALU_Out   (ALU_Out),
    .out_valid (out_valid),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // flags packed as {carry, zero, negative, overflow}
  function automatic logic [31:0] flags_now();
    return 32'({carry, zero, negative, overflow});
  endfunction

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    @(negedge clk);
    in_valid = 1'b1;
    A        = a;
    B        = b;
    ALU_Sel  = sel;
  endtask

  task automatic expect_res(input string tag, input logic [3:0] r, input logic [3:0] f,
                            input logic v);
    @(posedge clk);
    #1;
    check_eq({tag, "_out"}, 32'(ALU_Out), 32'(r));
    check_eq({tag, "_flg"}, flags_now(), 32'(f));
    check_eq({tag, "_vld"}, 32'(out_valid), 32'(v));
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_out"}, 32'(ALU_Out), 32'd0);
    check_eq({tag, "_flg"}, flags_now(), 32'd0);
    check_eq({tag, "_vld"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    A        = 4'd3;
    B        = 4'd1;
    ALU_Sel  = 3'b000;

    // reset held across edges with a valid op present
    repeat (3) @(posedge clk);
    #1;
    check_cleared("rst_hold");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // basic ops, A=0011 B=0001
    apply(4'b0011, 4'b0001, 3'b000); expect_res("add",  4'b0100, 4'b0000, 1'b1);
    apply(4'b0011, 4'b0001, 3'b001); expect_res("sub",  4'b0010, 4'b1000, 1'b1);
    apply(4'b0011, 4'b0001, 3'b010); expect_res("and",  4'b0001, 4'b0000, 1'b1);
    apply(4'b0011, 4'b0001, 3'b011); expect_res("or",   4'b0011, 4'b0000, 1'b1);
    apply(4'b0011, 4'b0001, 3'b100); expect_res("not",  4'b1100, 4'b0010, 1'b1);

    // wrap / flags
    apply(4'b1111, 4'b0001, 3'b000); expect_res("add_wrap", 4'b0000, 4'b1100, 1'b1);
    apply(4'b0111, 4'b0001, 3'b000); expect_res("add_ovf",  4'b1000, 4'b0011, 1'b1);
    apply(4'b0001, 4'b0010, 3'b001); expect_res("sub_brw",  4'b1111, 4'b0010, 1'b1);
    apply(4'b1000, 4'b0001, 3'b001); expect_res("sub_ovf",  4'b0111, 4'b1001, 1'b1);

    // remaining ops, A=1001 B=0011
    apply(4'b1001, 4'b0011, 3'b110); expect_res("shl", 4'b0010, 4'b1000, 1'b1);
    apply(4'b1001, 4'b0011, 3'b111); expect_res("shr", 4'b0100, 4'b1000, 1'b1);
    apply(4'b1001, 4'b0011, 3'b101); expect_res("xor", 4'b1010, 4'b0010, 1'b1);

    // idle: out_valid drops, result and flags hold while inputs toggle
    @(negedge clk);
    in_valid = 1'b0;
    A        = 4'($urandom_range(0, 15));
    B        = 4'($urandom_range(0, 15));
    ALU_Sel  = 3'b000;
    expect_res("idle1", 4'b1010, 4'b0010, 1'b0);
    #2;
    A = ~A;
    B = ~B;
    ALU_Sel = 3'b111;
    expect_res("idle2", 4'b1010, 4'b0010, 1'b0);

    // streaming: four back-to-back ops
    apply(4'b0010, 4'b0011, 3'b000); expect_res("st0", 4'b0101, 4'b0000, 1'b1);
    apply(4'b0101, 4'b0111, 3'b001); expect_res("st1", 4'b1110, 4'b0010, 1'b1);
    apply(4'b0101, 4'b1010, 3'b011); expect_res("st2", 4'b1111, 4'b0010, 1'b1);
    apply(4'b0110, 4'b0000, 3'b110); expect_res("st3", 4'b1100, 4'b0010, 1'b1);

    // asynchronous reset mid-cycle after a valid op
    apply(4'b0111, 4'b0001, 3'b000); expect_res("pre_rst", 4'b1000, 4'b0011, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("rst_async");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("post_rst");

    // first op after reset release
    apply(4'b0100, 4'b0100, 3'b001); expect_res("post_sub", 4'b0000, 4'b1100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
